// File: rtl/pipeline_hazard_ctrl_if.sv
// pipeline_hazard_ctrl_if: pipeline-to-hazard-controller signal bundle; slave is the controller.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  fd_rs1_i, fd_rs2_i, de_rs1_i, de_rs2_i, de_rd_i;
    logic        de_mem_read_i;
    logic [4:0]  em_write_addr_reg_i, mw_write_addr_reg_i;
    logic        em_reg_write_i, mw_reg_write_i;
    logic        e_pc_select_i, dmem_req_i, dmem_ready_i;
    logic        pc_stall_o, fd_stall_o, de_stall_o, em_stall_o;
    logic        fd_flush_o, de_flush_o, mw_flush_o;
    logic [1:0]  fwd_a_o, fwd_b_o, state_o;
    logic        dmem_timeout_o;
    logic [31:0] stall_cnt_o, flush_cnt_o;

    modport master (
        output fd_rs1_i, fd_rs2_i, de_rs1_i, de_rs2_i, de_rd_i, de_mem_read_i,
               em_write_addr_reg_i, em_reg_write_i, mw_write_addr_reg_i, mw_reg_write_i,
               e_pc_select_i, dmem_req_i, dmem_ready_i,
        input  pc_stall_o, fd_stall_o, de_stall_o, em_stall_o, fd_flush_o, de_flush_o,
               mw_flush_o, fwd_a_o, fwd_b_o, state_o, dmem_timeout_o, stall_cnt_o, flush_cnt_o
    );

    modport slave (
        input  fd_rs1_i, fd_rs2_i, de_rs1_i, de_rs2_i, de_rd_i, de_mem_read_i,
               em_write_addr_reg_i, em_reg_write_i, mw_write_addr_reg_i, mw_reg_write_i,
               e_pc_select_i, dmem_req_i, dmem_ready_i,
        output pc_stall_o, fd_stall_o, de_stall_o, em_stall_o, fd_flush_o, de_flush_o,
               mw_flush_o, fwd_a_o, fwd_b_o, state_o, dmem_timeout_o, stall_cnt_o, flush_cnt_o
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: forwarding, load-use/branch hazards and data-memory wait/timeout FSM.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255
) (
    input logic clk_i,
    input logic reset_i,
    pipeline_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {RUN = 2'b00, MEM_WAIT = 2'b01, ERROR = 2'b10} state_t;
    state_t state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic timeout, mem_stall, advance, branch, load_use, run;
    logic em_a, em_b, mw_a, mw_b;

    assign em_a = hz.em_reg_write_i && hz.em_write_addr_reg_i != 5'd0 && hz.em_write_addr_reg_i == hz.de_rs1_i;
    assign em_b = hz.em_reg_write_i && hz.em_write_addr_reg_i != 5'd0 && hz.em_write_addr_reg_i == hz.de_rs2_i;
    assign mw_a = hz.mw_reg_write_i && hz.mw_write_addr_reg_i != 5'd0 && hz.mw_write_addr_reg_i == hz.de_rs1_i;
    assign mw_b = hz.mw_reg_write_i && hz.mw_write_addr_reg_i != 5'd0 && hz.mw_write_addr_reg_i == hz.de_rs2_i;

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_stall    = 1'b0;
        advance      = 1'b0;
        case (state)
            RUN: begin
                if (hz.dmem_req_i && !hz.dmem_ready_i) begin
                    mem_stall    = 1'b1;
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = 8'd0;
                end else begin
                    advance = 1'b1;
                end
            end
            MEM_WAIT: begin
                if (hz.dmem_ready_i) begin
                    advance   = 1'b1;
                    state_nxt = RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (wait_cnt == 8'(MEM_TIMEOUT - 1)) state_nxt = ERROR;
                    else wait_cnt_nxt = wait_cnt + 8'd1;
                end
            end
            default: mem_stall = 1'b1;
        endcase
    end

    // Hazards are only acted on in cycles where the pipeline actually advances
    assign branch   = advance && hz.e_pc_select_i;
    assign load_use = advance && !hz.e_pc_select_i && hz.de_mem_read_i && hz.de_rd_i != 5'd0 &&
                      (hz.de_rd_i == hz.fd_rs1_i || hz.de_rd_i == hz.fd_rs2_i);
    assign run      = !reset_i;

    assign hz.pc_stall_o     = run && (mem_stall || load_use);
    assign hz.fd_stall_o     = run && (mem_stall || load_use);
    assign hz.de_stall_o     = run && mem_stall;
    assign hz.em_stall_o     = run && mem_stall;
    assign hz.mw_flush_o     = run && mem_stall;
    assign hz.fd_flush_o     = run && branch;
    assign hz.de_flush_o     = run && (branch || load_use);
    assign hz.fwd_a_o        = !run ? 2'b00 : em_a ? 2'b10 : mw_a ? 2'b01 : 2'b00;
    assign hz.fwd_b_o        = !run ? 2'b00 : em_b ? 2'b10 : mw_b ? 2'b01 : 2'b00;
    assign hz.state_o        = state;
    assign hz.dmem_timeout_o = timeout;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
            timeout  <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            timeout  <= timeout || state_nxt == ERROR;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_cnt <= 32'd0;
            flush_cnt <= 32'd0;
        end else begin
            stall_cnt <= stall_cnt + 32'(hz.pc_stall_o);
            flush_cnt <= flush_cnt + 32'(hz.fd_flush_o);
        end
    end
    assign hz.stall_cnt_o = stall_cnt;
    assign hz.flush_cnt_o = flush_cnt;
`else
    assign hz.stall_cnt_o = 32'd0;
    assign hz.flush_cnt_o = 32'd0;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of forwarding, hazards, memory wait and timeout.
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   passed = 0;

`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    pipeline_hazard_ctrl_if hz ();
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (.clk_i(clk), .reset_i(reset), .hz(hz.slave));

    always #5 clk = ~clk;

    // {pc_stall, fd_stall, de_stall, em_stall, fd_flush, de_flush, mw_flush}
    function automatic logic [6:0] outs();
        return {hz.pc_stall_o, hz.fd_stall_o, hz.de_stall_o, hz.em_stall_o,
                hz.fd_flush_o, hz.de_flush_o, hz.mw_flush_o};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic clear();
        hz.fd_rs1_i = 0; hz.fd_rs2_i = 0; hz.de_rs1_i = 0; hz.de_rs2_i = 0; hz.de_rd_i = 0;
        hz.de_mem_read_i = 0; hz.em_write_addr_reg_i = 0; hz.em_reg_write_i = 0;
        hz.mw_write_addr_reg_i = 0; hz.mw_reg_write_i = 0; hz.e_pc_select_i = 0;
        hz.dmem_req_i = 0; hz.dmem_ready_i = 0;
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1; clear();
        @(negedge clk); reset = 0;
    endtask

    initial begin
        clear();
        reset = 1;
        hz.em_reg_write_i = 1; hz.em_write_addr_reg_i = 5; hz.de_rs1_i = 5;
        hz.dmem_req_i = 1; hz.e_pc_select_i = 1;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_outs", 32'(outs()), 0);
        chk("rst_fwd_a", 32'(hz.fwd_a_o), 0);
        chk("rst_state", 32'(hz.state_o), 0);
        chk("rst_timeout", 32'(hz.dmem_timeout_o), 0);
        chk("rst_stall_cnt", hz.stall_cnt_o, 0);
        chk("rst_flush_cnt", hz.flush_cnt_o, 0);
        @(negedge clk); reset = 0; clear();

        hz.em_reg_write_i = 1; hz.em_write_addr_reg_i = 5;
        hz.mw_reg_write_i = 1; hz.mw_write_addr_reg_i = 5; hz.de_rs1_i = 5; hz.de_rs2_i = 0;
        #1;
        chk("fwd_a_em", 32'(hz.fwd_a_o), 2);
        chk("fwd_b_x0", 32'(hz.fwd_b_o), 0);
        hz.em_write_addr_reg_i = 0; #1;
        chk("fwd_a_mw", 32'(hz.fwd_a_o), 1);
        hz.em_write_addr_reg_i = 9; hz.de_rs2_i = 9; hz.mw_reg_write_i = 0; #1;
        chk("fwd_b_em", 32'(hz.fwd_b_o), 2);
        chk("fwd_a_none", 32'(hz.fwd_a_o), 0);

        @(negedge clk); clear();
        hz.de_mem_read_i = 1; hz.de_rd_i = 7; hz.fd_rs2_i = 7; #1;
        chk("load_use", 32'(outs()), 32'b1100010);
        hz.e_pc_select_i = 1; #1;
        chk("branch_over_lu", 32'(outs()), 32'b0000110);
        hz.e_pc_select_i = 0; hz.de_rd_i = 0; hz.fd_rs2_i = 0; #1;
        chk("load_use_x0", 32'(outs()), 0);
        @(negedge clk); clear(); #1;
        chk("idle", 32'(outs()), 0);

        pulse_reset();
        hz.dmem_req_i = 1; hz.dmem_ready_i = 1; #1;
        chk("zero_wait", 32'(outs()), 0);
        @(negedge clk); #1;
        chk("zero_wait_state", 32'(hz.state_o), 0);

        hz.dmem_req_i = 1; hz.dmem_ready_i = 0; hz.e_pc_select_i = 0; #1;
        chk("mem_stall_c1", 32'(outs()), 32'b1111001);
        @(negedge clk); #1;
        chk("mw_state_c2", 32'(hz.state_o), 1);
        chk("mw_stall_c2", 32'(outs()), 32'b1111001);
        hz.em_reg_write_i = 1; hz.em_write_addr_reg_i = 3; hz.de_rs1_i = 3; #1;
        chk("fwd_in_stall", 32'(hz.fwd_a_o), 2);
        @(negedge clk); #1;
        chk("mw_stall_c3", 32'(outs()), 32'b1111001);
        @(negedge clk); hz.dmem_ready_i = 1; #1;
        chk("mw_ready_outs", 32'(outs()), 0);
        chk("mw_ready_state", 32'(hz.state_o), 1);
        @(negedge clk); clear(); #1;
        chk("back_to_run", 32'(hz.state_o), 0);
        chk("stall_cnt3", hz.stall_cnt_o, PERF ? 32'd3 : 32'd0);

        pulse_reset();
        hz.dmem_req_i = 1; hz.e_pc_select_i = 1; #1;
        chk("br_mem_c1", 32'(outs()), 32'b1111001);
        @(negedge clk); #1;
        chk("br_mem_c2", 32'(outs()), 32'b1111001);
        @(negedge clk); hz.dmem_ready_i = 1; #1;
        chk("br_ready_flush", 32'(outs()), 32'b0000110);
        @(negedge clk); clear(); #1;
        chk("flush_cnt1", hz.flush_cnt_o, PERF ? 32'd1 : 32'd0);

        hz.dmem_req_i = 1; #1;
        @(negedge clk); #1;
        chk("mid_mw_state", 32'(hz.state_o), 1);
        pulse_reset(); #1;
        chk("mid_mw_reset", 32'(hz.state_o), 0);

        hz.dmem_req_i = 1;
        repeat (4) @(negedge clk);
        #1;
        chk("to_state_mw4", 32'(hz.state_o), 1);
        chk("to_no_flag", 32'(hz.dmem_timeout_o), 0);
        @(negedge clk); #1;
        chk("to_error", 32'(hz.state_o), 2);
        chk("to_flag", 32'(hz.dmem_timeout_o), 1);
        chk("to_stalls", 32'(outs()), 32'b1111001);
        @(negedge clk); hz.dmem_req_i = 0; hz.dmem_ready_i = 1; hz.e_pc_select_i = 1; #1;
        @(negedge clk); #1;
        chk("err_sticky", 32'(hz.state_o), 2);
        chk("err_stalls", 32'(outs()), 32'b1111001);
        @(negedge clk); reset = 1; #1;
        chk("err_rst_outs", 32'(outs()), 0);
        @(negedge clk); reset = 0; clear(); #1;
        chk("err_rst_state", 32'(hz.state_o), 0);
        chk("err_rst_flag", 32'(hz.dmem_timeout_o), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter: MEM_TIMEOUT, 255, MEM_WAIT cycles before ERROR (1..255).
REQ-002 SHALL have ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  reset; synchronous, active-high.
- fd_rs1_i, fd_rs2_i  in  5  source registers of the instruction in decode.
- de_rs1_i, de_rs2_i  in  5  source registers of the instruction in execute.
- de_rd_i  in  5  execute destination register.
- de_mem_read_i  in  1  execute holds a load.
- em_write_addr_reg_i  in  5  memory-stage destination register.
- em_reg_write_i  in  1  memory-stage register write.
- mw_write_addr_reg_i  in  5  writeback destination register.
- mw_reg_write_i  in  1  writeback register write.
- e_pc_select_i  in  1  branch/jump taken in execute.
- dmem_req_i  in  1  memory stage accessing data memory.
- dmem_ready_i  in  1  data memory completes this cycle.
- pc_stall_o, fd_stall_o, de_stall_o, em_stall_o  out  1  hold PC / pipeline register.
- fd_flush_o, de_flush_o, mw_flush_o  out  1  load bubble into register.
- fwd_a_o, fwd_b_o  out  2  ALU operand source: 00 register file, 01 writeback, 10 memory stage.
- state_o  out  2  FSM state: 00 RUN, 01 MEM_WAIT, 10 ERROR.
- dmem_timeout_o  out  1  sticky timeout flag.
- stall_cnt_o, flush_cnt_o  out  32  performance counters.

Function
REQ-003 SHALL compute fwd_a_o = 10 if em_reg_write_i, em_write_addr_reg_i != 0 and em_write_addr_reg_i == de_rs1_i; else 01 if the same holds for the mw_* signals; else 00. fwd_b_o uses de_rs2_i.
REQ-004 SHALL treat register x0 as never hazarding, for both forwarding and load-use.
REQ-005 SHALL detect load-use in RUN when de_mem_read_i, de_rd_i != 0, and de_rd_i equals fd_rs1_i or fd_rs2_i. Response in the same cycle: pc_stall_o=1, fd_stall_o=1, de_flush_o=1.
REQ-006 SHALL assert fd_flush_o=1 and de_flush_o=1 in the same cycle when in RUN with e_pc_select_i=1. Branch overrides load-use: no stall outputs are asserted.
REQ-007 In RUN with dmem_req_i=1 and dmem_ready_i=0, SHALL assert pc/fd/de/em stall and mw_flush_o in the same cycle, and go to MEM_WAIT. Branch and load-use outputs are suppressed.
REQ-008 In MEM_WAIT with dmem_ready_i=0, SHALL keep all four stalls and mw_flush_o asserted and increment the wait counter.
REQ-009 In MEM_WAIT with dmem_ready_i=1, SHALL deassert all stalls (pipeline advances), evaluate branch/load-use per REQ-005/006, and return to RUN next cycle.
REQ-010 In RUN with dmem_req_i=1 and dmem_ready_i=1, SHALL not stall (zero wait states).
REQ-011 SHALL clear the wait counter on entry to MEM_WAIT. When the counter reaches MEM_WAIT-cycle MEM_TIMEOUT with ready still 0, SHALL go to ERROR.
REQ-012 In ERROR, SHALL assert all stalls and mw_flush_o permanently and set dmem_timeout_o=1. Only reset_i exits ERROR.
REQ-013 Priority SHALL be ERROR > MEM_WAIT/memory stall > branch flush > load-use.
REQ-014 fwd_a_o and fwd_b_o SHALL be valid in every state, including stall states.

Reset
REQ-015 SHALL, on a clock edge with reset_i=1: state to RUN, wait counter to 0, dmem_timeout_o to 0, and perf counters to 0.
REQ-016 While reset_i=1, SHALL drive all stall/flush outputs to 0 and fwd_* to 00. Reset mid-MEM_WAIT or in ERROR SHALL return to RUN.

Configuration
REQ-017 With HAZARD_PERF_CNT_EN defined, SHALL implement:
- stall_cnt_o: increments each cycle pc_stall_o=1.
- flush_cnt_o: increments each cycle fd_flush_o=1.
- Both wrap at 2^32.
REQ-018 Without HAZARD_PERF_CNT_EN, stall_cnt_o and flush_cnt_o SHALL be constant 0 and no counter flops SHALL be built.

Verification
REQ-019 em_reg_write=1, em_rd=5, mw_reg_write=1, mw_rd=5, de_rs1=5, de_rs2=0 -> fwd_a=10, fwd_b=00. Set em_rd=0 -> fwd_a=01.
REQ-020 de_mem_read=1, de_rd=7, fd_rs2=7 -> pc_stall=fd_stall=de_flush=1 for one cycle. Add e_pc_select=1 -> fd_flush=de_flush=1, pc_stall=0.
REQ-021 dmem_req=1, ready low for 3 cycles, then high -> stalls high for exactly 3 cycles, state 01 then 00, stall_cnt=3 (macro on).
REQ-022 MEM_TIMEOUT=4, ready held low -> state=10 after 4 MEM_WAIT cycles, dmem_timeout=1 and stalls held. Then reset_i pulse -> state=00, dmem_timeout=0.
REQ-023 Branch taken during a memory stall -> no flush until ready. Flush asserts in the ready cycle; flush_cnt=1.
